// File: rtl/reverb_sample_sequencer.sv
// Sequences one audio channel through the reverb core: ADC sample in,
// parameter snapshot, core launch with timeout/dry fallback, DAC sample out.
module reverb_sample_sequencer #(
    parameter int DATA_W         = 24,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic              adc_ready,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    input  logic              dac_ready,
    output logic              proc_start,
    output logic [DATA_W-1:0] proc_in,
    input  logic              proc_done,
    input  logic [DATA_W-1:0] proc_out,
    input  logic              bypass,
    input  logic [DATA_W-1:0] decay_in,
    input  logic [DATA_W-1:0] damping_in,
    input  logic [DATA_W-1:0] mix_in,
    input  logic [DATA_W-1:0] predelay_in,
    output logic [DATA_W-1:0] decay_q,
    output logic [DATA_W-1:0] damping_q,
    output logic [DATA_W-1:0] mix_q,
    output logic [DATA_W-1:0] predelay_q,
    input  logic              clr_status,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  sample_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_STORE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_adc_ready;
    logic              r_proc_start;
    logic              r_dac_valid;
    logic              r_timeout_err;
    logic [DATA_W-1:0] r_sample;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_dac_data;
    logic [DATA_W-1:0] r_decay_q;
    logic [DATA_W-1:0] r_damping_q;
    logic [DATA_W-1:0] r_mix_q;
    logic [DATA_W-1:0] r_predelay_q;
    logic [TW-1:0]     r_timer;
    logic [CNT_W-1:0]  r_cnt;

    logic w_accept;
    logic w_done;
    logic w_timeout;
    logic w_load;

    assign w_accept  = adc_valid & r_adc_ready;
    assign w_done    = (r_state == S_WAIT) & proc_done;
    assign w_timeout = (r_state == S_WAIT) & ~proc_done & (r_timer == TLAST);
    assign w_load    = (r_state == S_STORE) & (~r_dac_valid | dac_ready);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = bypass ? S_STORE : S_START;
                end
            end
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (w_done || w_timeout) begin
                    w_next = S_STORE;
                end
            end
            S_STORE: begin
                if (w_load) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Decodes of the next state, registered so reset masks them cleanly
    always_ff @(posedge clk) begin
        if (reset) begin
            r_adc_ready  <= 1'b0;
            r_proc_start <= 1'b0;
        end else begin
            r_adc_ready  <= (w_next == S_IDLE);
            r_proc_start <= (w_next == S_START);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample     <= '0;
            r_decay_q    <= '0;
            r_damping_q  <= '0;
            r_mix_q      <= '0;
            r_predelay_q <= '0;
        end else if (w_accept) begin
            r_sample     <= adc_data;
            r_decay_q    <= decay_in;
            r_damping_q  <= damping_in;
            r_mix_q      <= mix_in;
            r_predelay_q <= predelay_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
        end else if (w_accept && bypass) begin
            r_result <= adc_data;
        end else if (w_done) begin
            r_result <= proc_out;
        end else if (w_timeout) begin
            r_result <= r_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (r_state == S_START) begin
            r_timer <= '0;
        end else if (r_state == S_WAIT && !proc_done) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Output register: a load may coincide with the sink consuming
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dac_valid <= 1'b0;
            r_dac_data  <= '0;
            r_cnt       <= '0;
        end else if (w_load) begin
            r_dac_valid <= 1'b1;
            r_dac_data  <= r_result;
            r_cnt       <= r_cnt + 1'b1;
        end else if (r_dac_valid && dac_ready) begin
            r_dac_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end else if (clr_status) begin
            r_timeout_err <= 1'b0;
        end
    end

    assign adc_ready   = r_adc_ready;
    assign proc_start  = r_proc_start;
    assign proc_in     = r_sample;
    assign dac_valid   = r_dac_valid;
    assign dac_data    = r_dac_data;
    assign decay_q     = r_decay_q;
    assign damping_q   = r_damping_q;
    assign mix_q       = r_mix_q;
    assign predelay_q  = r_predelay_q;
    assign timeout_err = r_timeout_err;
    assign sample_cnt  = r_cnt;

endmodule

// File: tb/tb_reverb_sample_sequencer.sv
// Bench for reverb_sample_sequencer: directed steps plus a random phase
// checked against a cycle-level reference model of samples and core replies.
module tb_reverb_sample_sequencer;

    localparam int DW    = 24;
    localparam int T     = 16;
    localparam int CW    = 4;
    localparam int NEVER = 1000000;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic          adc_ready;
    logic [DW-1:0] dac_data;
    logic          dac_valid;
    logic          dac_ready;
    logic          proc_start;
    logic [DW-1:0] proc_in;
    logic          proc_done;
    logic [DW-1:0] proc_out;
    logic          bypass;
    logic [DW-1:0] decay_in, damping_in, mix_in, predelay_in;
    logic [DW-1:0] decay_q, damping_q, mix_q, predelay_q;
    logic          clr_status;
    logic          timeout_err;
    logic [CW-1:0] sample_cnt;

    always #5 clk = ~clk;

    reverb_sample_sequencer #(
        .DATA_W(DW),
        .TIMEOUT_CYCLES(T),
        .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .adc_data(adc_data), .adc_valid(adc_valid), .adc_ready(adc_ready),
        .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
        .proc_start(proc_start), .proc_in(proc_in),
        .proc_done(proc_done), .proc_out(proc_out),
        .bypass(bypass),
        .decay_in(decay_in), .damping_in(damping_in),
        .mix_in(mix_in), .predelay_in(predelay_in),
        .decay_q(decay_q), .damping_q(damping_q),
        .mix_q(mix_q), .predelay_q(predelay_q),
        .clr_status(clr_status), .timeout_err(timeout_err),
        .sample_cnt(sample_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    int            m_start = -1000;
    int            m_done  = -1;
    int            m_to    = -1;
    logic [DW-1:0] m_done_val = '0;
    logic [DW-1:0] m_proc_in, m_dec, m_dam, m_mix, m_pre;
    bit            m_terr;
    int            m_cnt;
    logic [DW-1:0] q[$];

    bit            cfg_rand = 1'b0;
    bit            spur_en  = 1'b0;
    int            cfg_d    = 4;
    logic [DW-1:0] cfg_val  = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        chk("proc_start", 32'(proc_start), 32'(cyc == m_start));
        chk("proc_in", 32'(proc_in), 32'(m_proc_in));
        chk("decay_q", 32'(decay_q), 32'(m_dec));
        chk("damping_q", 32'(damping_q), 32'(m_dam));
        chk("mix_q", 32'(mix_q), 32'(m_mix));
        chk("predelay_q", 32'(predelay_q), 32'(m_pre));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        if (q.size() == 0) begin
            chk("dac_idle", 32'(dac_valid), 32'(0));
        end else if (dac_valid === 1'b1) begin
            chk("dac_data", 32'(dac_data), 32'(q[0]));
        end
    endtask

    task automatic accept();
        int            d;
        int            r;
        logic [DW-1:0] v;
        r = int'($urandom_range(0, 9));
        if (!cfg_rand) d = cfg_d;
        else if (r < 2) d = NEVER;
        else if (r == 2) d = T;
        else if (r == 3) d = 1;
        else d = int'($urandom_range(1, T));
        v = cfg_rand ? DW'($urandom) : cfg_val;
        m_cnt++;
        m_proc_in = adc_data;
        m_dec = decay_in;
        m_dam = damping_in;
        m_mix = mix_in;
        m_pre = predelay_in;
        if (bypass) begin
            q.push_back(adc_data);
        end else begin
            m_start = cyc + 1;
            if (d <= T) begin
                m_done = cyc + 1 + d;
                m_done_val = v;
                m_to = -1;
                q.push_back(v);
            end else begin
                m_done = -1;
                m_to = cyc + 1 + T;
                q.push_back(adc_data);
            end
        end
    endtask

    task automatic tick();
        if (cyc == m_done) begin
            proc_done = 1'b1;
            proc_out = m_done_val;
        end else if (spur_en && (cyc <= m_start || cyc > m_start + T)
                     && $urandom_range(0, 5) == 0) begin
            proc_done = 1'b1;
            proc_out = DW'($urandom);
        end else begin
            proc_done = 1'b0;
            proc_out = DW'($urandom);
        end
        if (reset) begin
            q.delete();
            m_start = -1000;
            m_to = -1;
            m_terr = 1'b0;
            m_cnt = 0;
            m_proc_in = '0;
            m_dec = '0;
            m_dam = '0;
            m_mix = '0;
            m_pre = '0;
        end else begin
            if (cyc == m_to) m_terr = 1'b1;
            else if (clr_status) m_terr = 1'b0;
            if (dac_valid === 1'b1 && dac_ready && q.size() > 0)
                void'(q.pop_front());
            if (adc_valid && adc_ready === 1'b1) accept();
        end
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic send(input logic [DW-1:0] data, input bit byp);
        int n;
        n = 0;
        adc_data = data;
        bypass = byp;
        adc_valid = 1'b1;
        while (adc_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("send_bound", 32'(adc_ready === 1'b1), 32'(1));
        tick();
        adc_valid = 1'b0;
        bypass = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        adc_valid = 1'b0;
        dac_ready = 1'b1;
        while (q.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        chk("drain_bound", 32'(q.size()), 32'(0));
        tick();
        chk("sample_cnt", 32'(sample_cnt), 32'(m_cnt & ((1 << CW) - 1)));
    endtask

    initial begin
        int s;
        int n;
        reset = 1'b1;
        adc_data = '0;
        adc_valid = 1'b0;
        dac_ready = 1'b0;
        proc_done = 1'b0;
        proc_out = '0;
        bypass = 1'b0;
        decay_in = 24'h000100;
        damping_in = 24'h000011;
        mix_in = 24'h000022;
        predelay_in = 24'h000033;
        clr_status = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_adc_ready", 32'(adc_ready), 32'(0));
        chk("rst_dac_data", 32'(dac_data), 32'(0));
        chk("rst_cnt", 32'(sample_cnt), 32'(0));
        reset = 1'b0;
        tick();
        chk("idle_adc_ready", 32'(adc_ready), 32'(1));

        // Processed path: core replies 5 cycles after acceptance
        dac_ready = 1'b1;
        cfg_d = 4;
        cfg_val = 24'h0ABCDE;
        send(24'h123456, 1'b0);
        chk("proc_in_dir", 32'(proc_in), 32'h123456);
        repeat (5) tick();
        chk("proc_lat_pre", 32'(dac_valid), 32'(0));
        tick();
        chk("proc_lat_valid", 32'(dac_valid), 32'(1));
        chk("proc_lat_data", 32'(dac_data), 32'h0ABCDE);
        drain();

        // Bypass: valid two cycles after acceptance, held one cycle
        send(24'h7FFFFF, 1'b1);
        chk("byp_pre", 32'(dac_valid), 32'(0));
        tick();
        chk("byp_valid", 32'(dac_valid), 32'(1));
        chk("byp_data", 32'(dac_data), 32'h7FFFFF);
        tick();
        chk("byp_post", 32'(dac_valid), 32'(0));
        drain();

        // Backpressure with three processed samples
        dac_ready = 1'b0;
        cfg_d = 2;
        cfg_val = 24'hA00001;
        send(24'h111111, 1'b0);
        cfg_val = 24'hA00002;
        send(24'h222222, 1'b0);
        adc_data = 24'h333333;
        adc_valid = 1'b1;
        cfg_val = 24'hA00003;
        repeat (40) tick();
        chk("bp_adc_ready", 32'(adc_ready), 32'(0));
        chk("bp_dac_valid", 32'(dac_valid), 32'(1));
        dac_ready = 1'b1;
        send(24'h333333, 1'b0);
        drain();

        // Timeout: dry fallback 18 cycles after proc_start
        cfg_d = NEVER;
        send(24'h800000, 1'b0);
        s = cyc;
        n = 0;
        while (dac_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("to_latency", 32'(cyc - s), 32'(18));
        chk("to_data", 32'(dac_data), 32'h800000);
        repeat (3) tick();
        chk("to_sticky", 32'(timeout_err), 32'(1));
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("to_clr", 32'(timeout_err), 32'(0));

        // A timeout beats a simultaneous clear
        clr_status = 1'b1;
        send(24'h400000, 1'b0);
        repeat (T) tick();
        tick();
        chk("to_set_wins", 32'(timeout_err), 32'(1));
        tick();
        chk("to_clr_after", 32'(timeout_err), 32'(0));
        clr_status = 1'b0;
        drain();

        // Parameter snapshot survives live changes mid-sample
        cfg_d = 10;
        cfg_val = 24'h055555;
        decay_in = 24'h000100;
        send(24'h0A0A0A, 1'b0);
        repeat (3) tick();
        decay_in = 24'h000200;
        repeat (3) tick();
        chk("snap_hold", 32'(decay_q), 32'h000100);
        drain();
        send(24'h0B0B0B, 1'b1);
        chk("snap_new", 32'(decay_q), 32'h000200);
        drain();

        // Reset while waiting on the core with an output pending
        dac_ready = 1'b0;
        send(24'h0F0F0F, 1'b1);
        cfg_d = 8;
        send(24'h010203, 1'b0);
        repeat (3) tick();
        chk("rw_pending", 32'(dac_valid), 32'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_valid", 32'(dac_valid), 32'(0));
        chk("rw_cnt", 32'(sample_cnt), 32'(0));
        dac_ready = 1'b1;
        repeat (12) tick();
        chk("rw_late_cnt", 32'(sample_cnt), 32'(0));
        chk("rw_late_valid", 32'(dac_valid), 32'(0));

        // Random traffic with random core latency and stray strobes
        cfg_rand = 1'b1;
        spur_en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            adc_valid = 1'($urandom_range(0, 1));
            adc_data = DW'($urandom);
            bypass = ($urandom_range(0, 3) == 0);
            dac_ready = ($urandom_range(0, 9) < 6);
            clr_status = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) begin
                decay_in = DW'($urandom);
                damping_in = DW'($urandom);
                mix_in = DW'($urandom);
                predelay_in = DW'($urandom);
            end
            tick();
        end
        clr_status = 1'b0;
        bypass = 1'b0;
        drain();
        chk("rand_terr", 32'(timeout_err), 32'(m_terr));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
